ring_buffer_reader: RTL

- Read side of the acoustics sample ring buffer. The writer fills a 2^ADDR_WIDTH-deep RAM with 10-bit hydrophone samples.
- On Trigger, this block captures a window of WINDOW_LEN samples, PRE_TRIGGER of them taken before the trigger.
- It waits for the post-trigger samples to land, then reads the window oldest-first from the RAM read port, handling address wrap-around.
- It streams the samples downstream over a valid/ready interface. Sits between the ring buffer RAM and the packetiser/DSP.

---
 rtl/ring_buffer_reader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ring_buffer_reader.sv
// ---------------------------------------------------------------------------
// ring_buffer_reader
//
// Read side of the acoustics sample ring buffer. On Trigger it captures a
// window of WINDOW_LEN samples, PRE_TRIGGER of them older than the trigger.
// It waits for the post-trigger samples to be written, then reads the window
// oldest-first from the RAM read port (wrapping at 2^ADDR_WIDTH). The samples
// leave through a valid/ready stream backed by a 2-entry skid buffer.
//
// Ports
//   Clk, Reset_N         system clock (rising edge), async active-low reset
//   Trigger              single-cycle capture request (honoured in IDLE only)
//   Sample_Strobe        writer write-enable, one pulse per sample
//   Write_Addr           address the writer is writing / will write next
//   RAM_Rd_En/_Addr      RAM read request; RAM_Rd_Data returns one cycle later
//   RAM_Rd_Data          RAM read data
//   Output_Data/_Valid   streamed sample and its qualifier
//   Output_Ready         downstream accept
//   Output_Last          marks the final sample of the window
//   Busy                 high whenever a capture is in progress
//   Read_Overrun         sticky: writer overwrote a not-yet-read window sample
// ---------------------------------------------------------------------------
module ring_buffer_reader #(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WINDOW_LEN  = 512,  // 1 .. 2^ADDR_WIDTH
  parameter int unsigned PRE_TRIGGER = 128   // 0 .. WINDOW_LEN
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  Trigger,
  input  logic                  Sample_Strobe,
  input  logic [ADDR_WIDTH-1:0] Write_Addr,
  output logic                  RAM_Rd_En,
  output logic [ADDR_WIDTH-1:0] RAM_Rd_Addr,
  input  logic [DATA_WIDTH-1:0] RAM_Rd_Data,
  output logic [DATA_WIDTH-1:0] Output_Data,
  output logic                  Output_Valid,
  input  logic                  Output_Ready,
  output logic                  Output_Last,
  output logic                  Busy,
  output logic                  Read_Overrun
);

  localparam int unsigned CNT_W = $clog2(WINDOW_LEN + 1);

  localparam logic [CNT_W-1:0]      WIN_LEN_C  = CNT_W'(WINDOW_LEN);
  localparam logic [CNT_W-1:0]      POST_LEN_C = CNT_W'(WINDOW_LEN - PRE_TRIGGER);
  localparam logic [CNT_W-1:0]      CNT_ONE_C  = CNT_W'(1);
  // Truncation gives the modulo-2^ADDR_WIDTH offset (PRE_TRIGGER may equal the depth).
  localparam logic [ADDR_WIDTH-1:0] PRE_OFS_C  = ADDR_WIDTH'(PRE_TRIGGER);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE_C = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POST_WAIT,
    S_READ
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      post_cnt_q;
  logic [CNT_W-1:0]      issue_cnt_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;      // holds Start_Addr until the first read
  logic                  inflight_q;    // a RAM read returns data this cycle
  logic                  inflight_last_q;
  logic                  overrun_q;

  // Skid buffer: entry 0 is the head presented on Output_Data.
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] skid_data_q [2];
  logic [DATA_WIDTH-1:0] skid_data_d [2];
  logic                  skid_last_q [2];
  logic                  skid_last_d [2];

  logic                  pop;
  logic [1:0]            occ_after_pop;
  logic                  rd_issue;
  logic                  overrun_hit;
  logic [CNT_W-1:0]      post_start;

  assign pop           = Output_Valid && Output_Ready;
  assign occ_after_pop = occ_q - {1'b0, pop};

  // Counting the slot freed by this cycle's transfer keeps one sample per
  // clock flowing with Output_Ready high; the buffer can never exceed 2.
  assign rd_issue = (state_q == S_READ) && (issue_cnt_q != '0) &&
                    ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);

  assign overrun_hit = Sample_Strobe && (Write_Addr == rd_ptr_q) && (issue_cnt_q != '0);

  // A strobe coincident with the accepted trigger is the first post sample.
  assign post_start = (Sample_Strobe && (POST_LEN_C != '0)) ? POST_LEN_C - CNT_ONE_C
                                                            : POST_LEN_C;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    occ_d       = occ_after_pop;
    if (pop) begin
      skid_data_d[0] = skid_data_q[1];
      skid_last_d[0] = skid_last_q[1];
    end
    // Returning data goes into the first free slot after the pop.
    if (inflight_q) begin
      skid_data_d[occ_after_pop[0]] = RAM_Rd_Data;
      skid_last_d[occ_after_pop[0]] = inflight_last_q;
      occ_d                         = occ_after_pop + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q         <= S_IDLE;
      post_cnt_q      <= '0;
      issue_cnt_q     <= '0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      overrun_q       <= 1'b0;
      occ_q           <= '0;
      // NOTE: the two skid entries are reset so Output_Data reads 0 after reset;
      // a deep RAM would normally be left unreset.
      for (int i = 0; i < 2; i++) begin
        skid_data_q[i] <= '0;
        skid_last_q[i] <= 1'b0;
      end
    end else begin
      skid_data_q     <= skid_data_d;
      skid_last_q     <= skid_last_d;
      occ_q           <= occ_d;
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && (issue_cnt_q == CNT_ONE_C);

      if (rd_issue) begin
        rd_ptr_q    <= rd_ptr_q + ADDR_ONE_C;
        issue_cnt_q <= issue_cnt_q - CNT_ONE_C;
      end

      case (state_q)
        S_IDLE: begin
          if (Trigger) begin
            rd_ptr_q    <= Write_Addr - PRE_OFS_C;
            issue_cnt_q <= WIN_LEN_C;
            post_cnt_q  <= post_start;
            overrun_q   <= 1'b0;
            state_q     <= (post_start == '0) ? S_READ : S_POST_WAIT;
          end
        end
        S_POST_WAIT: begin
          if (Sample_Strobe) begin
            post_cnt_q <= post_cnt_q - CNT_ONE_C;
            if (post_cnt_q == CNT_ONE_C) state_q <= S_READ;
          end
        end
        S_READ: begin
          if (overrun_hit) overrun_q <= 1'b1;
          if (pop && skid_last_q[0]) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RAM_Rd_En    = rd_issue;
  assign RAM_Rd_Addr  = rd_ptr_q;
  assign Output_Valid = (occ_q != '0);
  assign Output_Data  = skid_data_q[0];
  // Entry 0 may hold a stale flag once drained, so qualify with valid.
  assign Output_Last  = Output_Valid && skid_last_q[0];
  assign Busy         = (state_q != S_IDLE);
  assign Read_Overrun = overrun_q;

endmodule
